kbd_fifo: RTL and testbench



---
 rtl/kbd_pkg.sv | 6 +
 rtl/kbd_ack_sync.sv | 14 +
 rtl/kbd_fifo.sv | 84 ++++++++
 tb/tb_kbd_fifo.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared FSM states and constants for the keystroke FIFO
package kbd_pkg;
    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} kbd_state_e;
    localparam int KBD_DEFAULT_DEPTH_LOG2 = 4;
    localparam logic [7:0] KBD_EMPTY_DATA = 8'h00;
endpackage

// File: rtl/kbd_ack_sync.sv
// kbd_ack_sync: 2-flop synchronizer plus rising-edge detector for clk_cpu strobes
module kbd_ack_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);
    logic [2:0] s;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s <= '0;
        else     s <= {s[1:0], async_in};
    end
    assign pulse = s[1] & ~s[2];
endmodule

// File: rtl/kbd_fifo.sv
// kbd_fifo: keystroke FIFO between ps2_drv and the CPU keyboard interrupt
// Define KBD_FIFO_OVERWRITE_EN to drop the oldest key instead of back-pressuring when full.
module kbd_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH_LOG2 = KBD_DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_req,
    input  logic [7:0]            in_data,
    output logic                  in_ack,
    output logic                  out_int,
    output logic [7:0]            out_data,
    input  logic                  out_ack,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    kbd_state_e            state, state_nx;
    logic                  full, empty, push_ok, push, pop_edge, pop, drop;

    kbd_ack_sync u_ack_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (out_ack),
        .pulse    (pop_edge)
    );

    assign full  = count == FULL_CNT;
    assign empty = count == '0;
    assign pop   = pop_edge & ~empty;

`ifdef KBD_FIFO_OVERWRITE_EN
    assign push_ok = 1'b1;
    assign drop    = push & full & ~pop;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end
`else
    assign push_ok  = ~full;
    assign drop     = 1'b0;
    assign overflow = 1'b0;
`endif

    always_comb begin
        push     = state == IDLE && in_req && push_ok;
        state_nx = push ? ACK :
                   state == ACK ? WAIT_LOW :
                   (state == WAIT_LOW && !in_req) ? IDLE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // A drop keeps count at full: the write replaces the entry the read pointer skips.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)        wr_ptr <= wr_ptr + 1'b1;
            if (pop | drop)  rd_ptr <= rd_ptr + 1'b1;
            if (push & ~pop & ~drop) count <= count + 1'b1;
            else if (pop & ~push)    count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    assign in_ack   = state == ACK;
    assign out_int  = ~empty;
    assign out_data = empty ? KBD_EMPTY_DATA : mem[rd_ptr];
endmodule

// File: tb/tb_kbd_fifo.sv
// tb_kbd_fifo: directed scoreboard bench for kbd_fifo (default or overwrite build)
module tb_kbd_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_req = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ack;
    logic       out_int;
    logic [7:0] out_data;
    logic       out_ack = 1'b0;
    logic [4:0] count;
    logic       overflow;

    int         vectors = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    kbd_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .in_req   (in_req),
        .in_data  (in_data),
        .in_ack   (in_ack),
        .out_int  (out_int),
        .out_data (out_data),
        .out_ack  (out_ack),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // The CPU reads the head when it raises its acknowledge.
    always @(posedge out_ack) begin
        if (out_int) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected nothing", out_data);
            end else begin
                check("pop_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic push_key(input logic [7:0] d);
        int n;
        bit seen;
        seen = 1'b0;
        n = 0;
        @(negedge clk);
        in_req  = 1'b1;
        in_data = d;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            seen = in_ack;
        end
        check("push_ack_latency", seen ? n : 99, 1);
        if (seen) exp_q.push_back(d);
        in_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_key(input bit hold);
        int c;
        c = exp_q.size();
        @(negedge clk);
        out_ack = 1'b1;
        @(negedge clk);
        check("pop_lat_e", count, c);
        @(negedge clk);
        check("pop_lat_e1", count, c);
        @(negedge clk);
        check("pop_count", count, c - 1);
        if (hold) begin
            repeat (3) @(negedge clk);
            check("pop_once", count, c - 1);
        end
        out_ack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int acks, first;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ack", in_ack, 0);
        check("rst_out_int", out_int, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);

        acks = 0;
        first = -1;
        @(negedge clk);
        in_req  = 1'b1;
        in_data = 8'h41;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ack && first < 0) first = i;
            acks += int'(in_ack);
        end
        in_req = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back(8'h41);
        check("held_req_acks", acks, 1);
        check("held_req_ack_cycle", first, 0);
        check("one_count", count, 1);
        check("one_out_int", out_int, 1);
        check("one_out_data", out_data, 8'h41);

        pop_key(1'b1);
        check("empty_out_int", out_int, 0);
        check("empty_out_data", out_data, 8'h00);

        for (int i = 0; i < 16; i++) push_key(8'h30 + 8'(i));
        check("full_count", count, 16);
`ifdef KBD_FIFO_OVERWRITE_EN
        void'(exp_q.pop_front());
        push_key(8'h58);
        check("ovw_overflow", overflow, 1);
        check("ovw_count", count, 16);
        check("ovw_head", out_data, 8'h31);
`else
        @(negedge clk);
        in_req  = 1'b1;
        in_data = 8'h58;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            acks += int'(in_ack);
        end
        check("full_withheld_ack", acks, 0);
        check("full_hold_count", count, 16);
        check("full_overflow", overflow, 0);
        out_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("full_pop_count", count, 15);
        @(negedge clk);
        check("full_late_ack", in_ack, 1);
        check("full_refill_count", count, 16);
        exp_q.push_back(8'h58);
        in_req  = 1'b0;
        out_ack = 1'b0;
        repeat (3) @(negedge clk);
`endif
        for (int i = 0; i < 16; i++) pop_key(1'b0);
        check("drain_count", count, 0);

        push_key(8'h61);
        push_key(8'h62);
        push_key(8'h63);
        @(negedge clk);
        out_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_req  = 1'b1;
        in_data = 8'h64;
        @(negedge clk);
        check("simul_count", count, 3);
        check("simul_ack", in_ack, 1);
        check("simul_head", out_data, 8'h62);
        exp_q.push_back(8'h64);
        in_req  = 1'b0;
        out_ack = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) pop_key(1'b0);

        @(negedge clk);
        in_req  = 1'b1;
        in_data = 8'h71;
        @(negedge clk);
        check("ack_before_rst", in_ack, 1);
        check("count_before_rst", count, 1);
        rst = 1'b1;
        #1;
        check("rst_ack_async", in_ack, 0);
        check("rst_count_async", count, 0);
        check("rst_int_async", out_int, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        in_data = 8'h72;
        @(negedge clk);
        check("idle_after_rst", in_ack, 1);
        check("count_after_rst", count, 1);
        exp_q.push_back(8'h72);
        in_req = 1'b0;
        repeat (2) @(negedge clk);
        pop_key(1'b0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
